udt_mac_tx_arb: RTL and testbench
=================================

// Module: udt_mac_tx_arb
// PURPOSE
//  Packet-granular round-robin arbiter merging NUM_CH client AXI-Stream TX channels (udt_top instances
//  or other user sources) onto one MAC TX AXI-Stream. Tags each output packet with its source channel,
//  registers the output for timing, and enforces a maximum packet length (truncate + drain).
//  Generalised successor of the single-client MAC attach: width, channel count and length limit set by parameters.
// PARAMETERS
//  NUM_CH     4     number of client channels (2..16)
//  DATA_W     64    stream data width, bits (multiple of 8); KEEP_W = DATA_W/8
//  MAX_BEATS  190   max beats per packet before forced truncation (>=2)
//  CH_W       2     channel index width, >= clog2(NUM_CH)
// PORTS
//  core_clk        in   1              sole clock
//  core_rst_n      in   1              synchronous reset, active low
//  ch_enable       in   NUM_CH         per-channel arbitration enable; sampled only in IDLE
//  s_axis_tvalid   in   NUM_CH         client valid, one bit per channel
//  s_axis_tready   out  NUM_CH         client ready
//  s_axis_tlast    in   NUM_CH         client end of packet
//  s_axis_tkeep    in   NUM_CH*KEEP_W  client byte enables, channel i at [i*KEEP_W +: KEEP_W]
//  s_axis_tdata    in   NUM_CH*DATA_W  client data, channel i at [i*DATA_W +: DATA_W]
//  m_axis_tvalid   out  1              MAC TX valid (registered)
//  m_axis_tready   in   1              MAC TX ready
//  m_axis_tlast    out  1              MAC TX end of packet
//  m_axis_tkeep    out  KEEP_W         MAC TX byte enables
//  m_axis_tdata    out  DATA_W         MAC TX data
//  m_axis_tid      out  CH_W           source channel of current beat
//  trunc_pulse     out  1              one-cycle pulse: packet truncated
//  trunc_ch        out  CH_W           channel of last truncation (held)
// BEHAVIOUR
//  Reset (core_rst_n=0 at posedge): state=IDLE; all outputs 0; rr pointer=NUM_CH-1; beat counter=0.
//  Output stage: single register. Load when (!m_axis_tvalid || m_axis_tready). Sole storage; no skid beyond it.
//  s_axis_tready[i] = (state==BUSY || state==DRAIN) && grant==i && (!m_axis_tvalid || m_axis_tready)
//    in BUSY; in DRAIN tready[grant]=1 unconditionally. All other bits 0.
//  IDLE: req = s_axis_tvalid & ch_enable. If req!=0, grant = first set bit searching from rr+1 upward
//    (wrapping); rr<=grant; beat_cnt<=0; ->BUSY next cycle. No data moves in IDLE (1-cycle bubble per packet).
//  BUSY: each accepted beat (tvalid&tready on grant) loads output register with data/keep/last/tid=grant;
//    beat_cnt++. Accepted beat with tlast -> IDLE.
//    Accepted beat number MAX_BEATS without tlast: output beat forced tlast=1, trunc_pulse=1 next cycle,
//    trunc_ch<=grant; -> DRAIN. Beat carrying tlast at exactly MAX_BEATS is normal (no truncation).
//  DRAIN: input beats of grant discarded (never reach output) until one with tlast accepted -> IDLE.
//  Latency: input beat accepted in cycle N appears on m_axis in cycle N+1. Back-to-back within a packet
//    at full throughput while m_axis_tready=1.
//  m_axis_tvalid deasserts only after a handshake with no new beat loaded; output held stable while
//    tvalid=1 and tready=0 (AXIS rule). tvalid never depends on tready combinationally.
//  ch_enable dropped mid-packet: no effect until packet ends (grant held to tlast).
//  Single requester: served every packet, 1 idle cycle between packets. rr wrap: NUM_CH-1 -> 0.
//  Reset mid-packet: immediate return to IDLE, output valid cleared; partial packet lost by design.
//  beat_cnt width clog2(MAX_BEATS+1), saturates; never wraps.
// TESTING
//  1. Reset with all inputs valid -> all outputs 0, s_axis_tready=0 during reset cycle and the cycle after.
//  2. Ch0..3 each present a 4-beat packet simultaneously, m_tready=1 -> tid order 0,1,2,3; 4 beats each,
//     1 idle cycle between packets; data matches byte-for-byte.
//  3. Ch2 sends 200-beat packet, MAX_BEATS=190 -> 190 beats out, beat 190 tlast=1, trunc_pulse once,
//     trunc_ch=2; remaining 10 input beats consumed, none output; next packet arbitrates normally.
//  4. Random m_tready (50%) with 3 channels streaming random lengths 1..64 -> no beat lost/duplicated,
//     per-channel order preserved, output stable while stalled.
//  5. ch_enable=4'b1010, all valid -> only channels 1 and 3 granted, alternating; deasserting bit 1 mid-packet
//     completes that packet.
//  6. Assert core_rst_n=0 during beat 3 of a 6-beat packet -> next cycle m_axis_tvalid=0, state IDLE, clean restart.

Source files
------------

// File: rtl/udt_mac_tx_arb_if.sv
// Stream bundle between the client TX channels, the arbiter and the MAC TX port.
// The master modport is the arbiter side; the slave modport is the clients/MAC side.
interface udt_mac_tx_arb_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int CH_W   = 2
) ();
  localparam int KEEP_W = DATA_W / 8;

  logic [NUM_CH-1:0]        s_axis_tvalid;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [NUM_CH-1:0]        s_axis_tlast;
  logic [NUM_CH*KEEP_W-1:0] s_axis_tkeep;
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata;

  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tlast;
  logic [KEEP_W-1:0]        m_axis_tkeep;
  logic [DATA_W-1:0]        m_axis_tdata;
  logic [CH_W-1:0]          m_axis_tid;

  modport master (
    input  s_axis_tvalid, s_axis_tlast, s_axis_tkeep, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, m_axis_tid
  );

  modport slave (
    output s_axis_tvalid, s_axis_tlast, s_axis_tkeep, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, m_axis_tid
  );
endinterface

// File: rtl/udt_mac_tx_arb.sv
// Packet-granular round-robin merge of NUM_CH client streams onto one registered MAC TX stream,
// tagging each beat with its source channel and truncating packets longer than MAX_BEATS.
module udt_mac_tx_arb #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 190,
  parameter int CH_W      = 2
) (
  input  logic              core_clk,
  input  logic              core_rst_n,
  input  logic [NUM_CH-1:0] ch_enable,
  udt_mac_tx_arb_if.master  axis,
  output logic              trunc_pulse,
  output logic [CH_W-1:0]   trunc_ch
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CH_W-1:0]   r_grant;
  logic [CH_W-1:0]   w_grant_next;
  logic [CH_W-1:0]   r_rr;
  logic [CH_W-1:0]   w_rr_next;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  w_beat_cnt_next;

  logic              r_m_valid;
  logic              r_m_last;
  logic [KEEP_W-1:0] r_m_keep;
  logic [DATA_W-1:0] r_m_data;
  logic [CH_W-1:0]   r_m_tid;
  logic              r_trunc_pulse;
  logic [CH_W-1:0]   r_trunc_ch;

  logic [NUM_CH-1:0] w_req;
  logic [CH_W-1:0]   w_idx;
  logic [CH_W-1:0]   w_pick;
  logic              w_found;
  logic              w_load_ok;
  logic              w_path_open;
  logic              w_accept;
  logic              w_load;
  logic              w_trunc;
  logic              w_at_limit;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic [KEEP_W-1:0] w_sel_keep;
  logic [DATA_W-1:0] w_sel_data;
  logic [NUM_CH-1:0] w_s_tready;

  // Granted channel's beat, selected once so the datapath only sees one stream.
  assign w_sel_valid = axis.s_axis_tvalid[r_grant];
  assign w_sel_last  = axis.s_axis_tlast[r_grant];
  assign w_sel_keep  = axis.s_axis_tkeep[r_grant*KEEP_W +: KEEP_W];
  assign w_sel_data  = axis.s_axis_tdata[r_grant*DATA_W +: DATA_W];

  assign w_load_ok   = !r_m_valid || axis.m_axis_tready;
  assign w_path_open = ((r_state == ST_BUSY) && w_load_ok) || (r_state == ST_DRAIN);
  assign w_accept    = core_rst_n && w_path_open && w_sel_valid;
  assign w_at_limit  = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));

  // Ready is gated by reset so no client beat is consumed in the reset cycle itself.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_tready
    assign w_s_tready[gi] = core_rst_n && w_path_open && (r_grant == CH_W'(gi));
  end
  assign axis.s_axis_tready = w_s_tready;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    w_req   = axis.s_axis_tvalid & ch_enable;
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = CH_W'((int'(r_rr) + k) % NUM_CH);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_rr_next       = r_rr;
    w_beat_cnt_next = r_beat_cnt;
    w_load          = 1'b0;
    w_trunc         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_next    = w_pick;
          w_rr_next       = w_pick;
          w_beat_cnt_next = '0;
          w_state_next    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (r_beat_cnt != CNT_W'(MAX_BEATS)) begin
            w_beat_cnt_next = r_beat_cnt + 1'b1;
          end
          if (w_sel_last) begin
            w_state_next = ST_IDLE;
          end else if (w_at_limit) begin
            w_trunc      = 1'b1;
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_accept && w_sel_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_rr          <= CH_W'(NUM_CH - 1);
      r_beat_cnt    <= '0;
      r_m_valid     <= 1'b0;
      r_m_last      <= 1'b0;
      r_m_keep      <= '0;
      r_m_data      <= '0;
      r_m_tid       <= '0;
      r_trunc_pulse <= 1'b0;
      r_trunc_ch    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_rr          <= w_rr_next;
      r_beat_cnt    <= w_beat_cnt_next;
      r_trunc_pulse <= w_trunc;
      if (w_trunc) begin
        r_trunc_ch <= r_grant;
      end
      // Single output register: refill on accept, otherwise empty it once the MAC takes it.
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_last  <= w_sel_last || w_trunc;
        r_m_keep  <= w_sel_keep;
        r_m_data  <= w_sel_data;
        r_m_tid   <= r_grant;
      end else if (axis.m_axis_tready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign axis.m_axis_tvalid = r_m_valid;
  assign axis.m_axis_tlast  = r_m_last;
  assign axis.m_axis_tkeep  = r_m_keep;
  assign axis.m_axis_tdata  = r_m_data;
  assign axis.m_axis_tid    = r_m_tid;
  assign trunc_pulse        = r_trunc_pulse;
  assign trunc_ch           = r_trunc_ch;
endmodule

// File: tb/tb_udt_mac_tx_arb.sv
// Randomized bench for udt_mac_tx_arb: client packets are queued per channel, a packet-level
// round-robin model builds the expected MAC beat sequence, and every MAC handshake is scored.
module tb_udt_mac_tx_arb;
  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 64;
  localparam int MAX_BEATS = 190;
  localparam int CH_W      = 2;
  localparam int KEEP_W    = DATA_W / 8;

  typedef struct packed {
    logic              first;
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [CH_W-1:0]   tid;
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } obeat_t;

  logic              core_clk = 1'b0;
  logic              core_rst_n;
  logic [NUM_CH-1:0] ch_enable;
  logic              trunc_pulse;
  logic [CH_W-1:0]   trunc_ch;

  always #5 core_clk = ~core_clk;

  udt_mac_tx_arb_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  udt_mac_tx_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .CH_W(CH_W)) dut (
    .core_clk    (core_clk),
    .core_rst_n  (core_rst_n),
    .ch_enable   (ch_enable),
    .axis        (bus),
    .trunc_pulse (trunc_pulse),
    .trunc_ch    (trunc_ch)
  );

  beat_t  src_q [NUM_CH][$];
  beat_t  mdl_q [NUM_CH][$];
  int     len_q [NUM_CH][$];
  obeat_t exp_q [$];

  int              n_vec = 0;
  int              n_err = 0;
  int              cyc = 0;
  int              mdl_rr = NUM_CH - 1;
  int              rdy_pct = 100;
  bit              gap_en = 1'b0;
  logic [NUM_CH-1:0] hs_prev = '0;
  int              in_hs_cnt [NUM_CH];
  int              out_cnt [NUM_CH];
  int              pulse_cnt = 0;
  int              exp_trunc_cnt = 0;
  logic [CH_W-1:0] exp_trunc_ch = '0;
  bit              stall_prev = 1'b0;
  logic [127:0]    snap = '0;
  int              first_hs_cyc = -1;
  int              last_hs_cyc = -1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic add_pkt(input int ch, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.first = (b == 0);
      bt.last  = (b == len - 1);
      bt.keep  = KEEP_W'($urandom);
      bt.data  = {$urandom, $urandom};
      src_q[ch].push_back(bt);
      mdl_q[ch].push_back(bt);
    end
    len_q[ch].push_back(len);
  endtask

  // Packet-level reference: pick the next enabled channel with a pending packet after the
  // last one served, emit its beats, and cut it to MAX_BEATS with tlast forced on the last kept beat.
  task automatic plan(input logic [NUM_CH-1:0] mask);
    int     ch;
    int     c;
    int     len;
    bit     found;
    beat_t  bt;
    obeat_t ob;
    forever begin
      found = 1'b0;
      ch = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (mdl_rr + k) % NUM_CH;
        if (!found && mask[c] && len_q[c].size() > 0) begin
          found = 1'b1;
          ch = c;
        end
      end
      if (!found) break;
      mdl_rr = ch;
      len = len_q[ch].pop_front();
      for (int b = 0; b < len; b++) begin
        bt = mdl_q[ch].pop_front();
        if (b < MAX_BEATS) begin
          ob.tid  = CH_W'(ch);
          ob.last = bt.last || (b == MAX_BEATS - 1);
          ob.keep = bt.keep;
          ob.data = bt.data;
          exp_q.push_back(ob);
        end
      end
      if (len > MAX_BEATS) begin
        exp_trunc_cnt++;
        exp_trunc_ch = CH_W'(ch);
      end
    end
  endtask

  function automatic bit all_done(input logic [NUM_CH-1:0] mask);
    bit d;
    d = (exp_q.size() == 0) && !bus.m_axis_tvalid;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c] && src_q[c].size() != 0) d = 1'b0;
    end
    return d;
  endfunction

  // One clock: retire last edge's client handshakes, drive new inputs, then score the MAC side.
  task automatic step(input bit do_rst);
    obeat_t ob;
    @(negedge core_clk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (hs_prev[c]) begin
        void'(src_q[c].pop_front());
        in_hs_cnt[c]++;
      end
    end
    core_rst_n = !do_rst;
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_q[c].size() == 0) begin
        bus.s_axis_tvalid[c] = 1'b0;
      end else begin
        if (!bus.s_axis_tvalid[c] || hs_prev[c]) begin
          bus.s_axis_tvalid[c] = src_q[c][0].first || !gap_en || ($urandom_range(0, 3) != 0);
        end
        bus.s_axis_tlast[c]                  = src_q[c][0].last;
        bus.s_axis_tkeep[c*KEEP_W +: KEEP_W] = src_q[c][0].keep;
        bus.s_axis_tdata[c*DATA_W +: DATA_W] = src_q[c][0].data;
      end
    end
    bus.m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
    #1;
    cyc++;
    if (do_rst) begin
      hs_prev    = '0;
      stall_prev = 1'b0;
      return;
    end
    hs_prev = bus.s_axis_tvalid & bus.s_axis_tready;
    if (trunc_pulse) begin
      pulse_cnt++;
      chk("trunc_ch", trunc_ch, exp_trunc_ch);
    end
    if (stall_prev) begin
      chk("stall_hold", {bus.m_axis_tvalid, bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata}, snap);
    end
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", bus.m_axis_tvalid, 1'b0);
      end else begin
        ob = exp_q.pop_front();
        chk("beat", {bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata}, ob);
        out_cnt[bus.m_axis_tid]++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
      end
    end
    stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
    snap = {bus.m_axis_tvalid, bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata};
  endtask

  task automatic run(input string tag, input logic [NUM_CH-1:0] mask, input int budget);
    int n;
    n = 0;
    while (!all_done(mask) && n < budget) begin
      step(1'b0);
      n++;
    end
    chk(tag, all_done(mask), 1'b1);
  endtask

  initial begin
    int base;
    int n;
    for (int c = 0; c < NUM_CH; c++) begin
      in_hs_cnt[c] = 0;
      out_cnt[c]   = 0;
    end

    // Reset with every client valid: outputs cleared, no client ready during or right after reset.
    core_rst_n        = 1'b0;
    ch_enable         = '1;
    bus.s_axis_tvalid = '1;
    bus.s_axis_tlast  = '1;
    bus.s_axis_tkeep  = '1;
    bus.s_axis_tdata  = {NUM_CH{64'hA5A5_5A5A_DEAD_BEEF}};
    bus.m_axis_tready = 1'b1;
    @(negedge core_clk); #1;
    chk("rst_tready_in_reset", bus.s_axis_tready, '0);
    @(posedge core_clk); #1;
    chk("rst_m_valid", bus.m_axis_tvalid, 1'b0);
    chk("rst_m_fields", {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata, bus.m_axis_tid}, '0);
    chk("rst_trunc", {trunc_pulse, trunc_ch}, '0);
    @(negedge core_clk);
    core_rst_n = 1'b1;
    #1;
    chk("rst_tready_after", bus.s_axis_tready, '0);
    chk("rst_valid_after", bus.m_axis_tvalid, 1'b0);
    @(negedge core_clk);
    core_rst_n        = 1'b0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    @(negedge core_clk);
    core_rst_n = 1'b1;
    hs_prev    = '0;

    // Four simultaneous 4-beat packets: order 0,1,2,3 with one bubble between packets.
    rdy_pct = 100;
    gap_en  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) add_pkt(c, 4);
    plan('1);
    first_hs_cyc = -1;
    run("t2_done", '1, 500);
    chk("t2_span", last_hs_cyc - first_hs_cyc, 4 * 4 + 3 - 1);

    // Oversized packet on channel 2 is cut at MAX_BEATS and its tail drained; channel 3 follows.
    add_pkt(2, 200);
    add_pkt(3, 5);
    base = out_cnt[2];
    pulse_cnt = 0;
    exp_trunc_cnt = 0;
    plan('1);
    run("t3_done", '1, 2000);
    chk("t3_trunc_cnt", pulse_cnt, 1);
    chk("t3_out_beats", out_cnt[2] - base, MAX_BEATS);
    chk("t3_trunc_ch_held", trunc_ch, 2'd2);

    // Three channels with random lengths, random client gaps and a 50% MAC ready.
    rdy_pct = 50;
    gap_en  = 1'b1;
    for (int p = 0; p < 6; p++) begin
      add_pkt(0, $urandom_range(1, 64));
      add_pkt(1, $urandom_range(1, 64));
      add_pkt(3, $urandom_range(1, 64));
    end
    plan('1);
    run("t4_done", '1, 20000);

    // Only channels 1 and 3 enabled; channel 1 loses its enable mid-packet and still finishes.
    rdy_pct   = 80;
    ch_enable = 4'b1010;
    add_pkt(1, 6);
    add_pkt(1, 6);
    add_pkt(3, 5);
    add_pkt(3, 5);
    add_pkt(0, 3);
    add_pkt(2, 3);
    plan(4'b1010);
    base = in_hs_cnt[1];
    n = 0;
    while (!all_done(4'b1010) && n < 3000) begin
      step(1'b0);
      if (in_hs_cnt[1] == base + 8) ch_enable = 4'b1000;
      n++;
    end
    chk("t5_done", all_done(4'b1010), 1'b1);
    chk("t5_ch0_parked", src_q[0].size(), 3);
    chk("t5_ch2_parked", src_q[2].size(), 3);
    ch_enable = '1;
    plan('1);
    run("t5_flush", '1, 1000);

    // Reset while beat 3 of a 6-beat packet is offered, then a clean restart from a fresh pointer.
    rdy_pct = 100;
    gap_en  = 1'b0;
    add_pkt(1, 6);
    plan('1);
    base = in_hs_cnt[1];
    n = 0;
    while (in_hs_cnt[1] < base + 2 && n < 200) begin
      step(1'b0);
      n++;
    end
    chk("t6_reach_beat3", in_hs_cnt[1] - base, 2);
    step(1'b1);
    for (int c = 0; c < NUM_CH; c++) begin
      src_q[c].delete();
      mdl_q[c].delete();
      len_q[c].delete();
    end
    exp_q.delete();
    mdl_rr = NUM_CH - 1;
    step(1'b0);
    chk("t6_valid_cleared", bus.m_axis_tvalid, 1'b0);
    chk("t6_tready_idle", bus.s_axis_tready, '0);
    add_pkt(2, 6);
    add_pkt(0, 3);
    plan('1);
    run("t6_restart", '1, 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
